branch_predictor: RTL

Direct-mapped branch target buffer with 2-bit saturating direction counters. IF looks up the fetch PC each cycle and gets a predicted-taken flag and target. EX writes back the resolved outcome from the branch compare unit (`branch_decision`) and the computed target. The block also flags mispredicts so the front end can be redirected, and keeps performance counters.

---
 rtl/bp_pkg.sv | 26 ++
 rtl/bp_sat_counter.sv | 24 ++
 rtl/branch_predictor.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor: direction-counter
// encodings and the per-entry status record.
package bp_pkg;

   // 2-bit saturating direction counter; the MSB is the taken prediction.
   typedef enum logic [1:0] {
      BP_SNT = 2'd0,   // strongly not taken
      BP_WNT = 2'd1,   // weakly not taken
      BP_WT  = 2'd2,   // weakly taken
      BP_ST  = 2'd3    // strongly taken
   } bp_ctr_e;

   // Value after reset, and value given to a newly allocated entry.
   localparam bp_ctr_e BP_CTR_RESET = BP_WNT;
   localparam bp_ctr_e BP_CTR_ALLOC = BP_WT;

   // Per-entry status. Tag and target widths depend on the top-level
   // parameters, so those fields live in parameterised arrays beside it.
   typedef struct packed {
      logic    valid;
      bp_ctr_e ctr;
   } bp_entry_t;

   localparam bp_entry_t BP_ENTRY_RESET = '{valid: 1'b0, ctr: BP_CTR_RESET};

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter.
module bp_sat_counter
   import bp_pkg::*;
(
   input  bp_ctr_e ctr_i,
   input  logic    taken_i,
   output bp_ctr_e ctr_o
);

   // Count up on taken, down on not taken, clamping at both ends.
   always_comb begin
      ctr_o = ctr_i;
      if (taken_i) begin
         if (ctr_i != BP_ST) begin
            ctr_o = bp_ctr_e'(ctr_i + 2'd1);
         end
      end else begin
         if (ctr_i != BP_SNT) begin
            ctr_o = bp_ctr_e'(ctr_i - 2'd1);
         end
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, mispredict redirect and
// performance counters. The table is built from flops so that valid/ctr can
// be cleared asynchronously and read combinationally by fetch.
module branch_predictor
   import bp_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int ENTRIES    = 64,
   localparam int IDX_W      = $clog2(ENTRIES),
   localparam int TAG_W      = DATA_WIDTH - IDX_W - 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] if_pc,
   output logic                  pred_taken,
   output logic [DATA_WIDTH-1:0] pred_target,
   input  logic                  upd_valid,
   input  logic [DATA_WIDTH-1:0] upd_pc,
   input  logic                  upd_taken,
   input  logic [DATA_WIDTH-1:0] upd_target,
   input  logic                  upd_pred_taken,
   input  logic [DATA_WIDTH-1:0] upd_pred_target,
   output logic                  redirect_valid,
   output logic [DATA_WIDTH-1:0] redirect_pc,
   output logic [31:0]           branch_cnt,
   output logic [31:0]           mispredict_cnt
);

   // Read views of the per-entry registers held in the generate blocks.
   bp_entry_t             stat_rd   [ENTRIES];
   logic [TAG_W-1:0]      tag_rd    [ENTRIES];
   logic [DATA_WIDTH-1:0] target_rd [ENTRIES];

   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             if_hit;
   logic             upd_hit;
   bp_entry_t        upd_stat;
   bp_ctr_e          upd_ctr_next;

   // Write controls shared by every entry; only the indexed one acts on them.
   bp_entry_t stat_d;
   logic      stat_we;
   logic      tag_we;
   logic      target_we;

   logic        redirect_raw;
   logic [31:0] branch_cnt_q;
   logic [31:0] mispredict_cnt_q;

   // Word-aligned PCs: the two LSBs never select or tag an entry.
   logic unused_if_pc_lsb;
   assign unused_if_pc_lsb = ^if_pc[1:0];

   assign if_idx  = if_pc[IDX_W+1:2];
   assign if_tag  = if_pc[DATA_WIDTH-1:IDX_W+2];
   assign upd_idx = upd_pc[IDX_W+1:2];
   assign upd_tag = upd_pc[DATA_WIDTH-1:IDX_W+2];

   // Fetch lookup: zero-latency, reflects the table as of the last edge.
   always_comb begin
      if_hit      = stat_rd[if_idx].valid && (tag_rd[if_idx] == if_tag);
      pred_taken  = if_hit && stat_rd[if_idx].ctr[1];
      pred_target = pred_taken ? target_rd[if_idx] : '0;
   end

   // Update-side view of the entry the resolving branch maps to.
   always_comb begin
      upd_stat = stat_rd[upd_idx];
      upd_hit  = upd_stat.valid && (tag_rd[upd_idx] == upd_tag);
   end

   bp_sat_counter u_sat_counter (
      .ctr_i   (upd_stat.ctr),
      .taken_i (upd_taken),
      .ctr_o   (upd_ctr_next)
   );

   // Decide what the resolving branch writes: train on hit, allocate on a
   // taken miss (evicting any alias), leave a not-taken miss alone.
   always_comb begin
      stat_d    = upd_stat;
      stat_we   = 1'b0;
      tag_we    = 1'b0;
      target_we = 1'b0;
      if (upd_valid) begin
         if (upd_hit) begin
            stat_we    = 1'b1;
            stat_d.ctr = upd_ctr_next;
            target_we  = upd_taken;
         end else if (upd_taken) begin
            stat_we   = 1'b1;
            stat_d    = '{valid: 1'b1, ctr: BP_CTR_ALLOC};
            tag_we    = 1'b1;
            target_we = 1'b1;
         end
      end
   end

   for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      bp_entry_t             stat_q;
      logic [TAG_W-1:0]      tag_q;
      logic [DATA_WIDTH-1:0] target_q;
      logic                  sel;

      assign sel = (upd_idx == IDX_W'(gi));

      // Entry storage: cleared by reset, written only when indexed.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            stat_q   <= BP_ENTRY_RESET;
            tag_q    <= '0;
            target_q <= '0;
         end else if (sel) begin
            if (stat_we) begin
               stat_q <= stat_d;
            end
            if (tag_we) begin
               tag_q <= upd_tag;
            end
            if (target_we) begin
               target_q <= upd_target;
            end
         end
      end

      assign stat_rd[gi]   = stat_q;
      assign tag_rd[gi]    = tag_q;
      assign target_rd[gi] = target_q;
   end

   // Mispredict detection; forced quiet while reset is held.
   always_comb begin
      redirect_raw = upd_valid &&
                     ((upd_taken != upd_pred_taken) ||
                      (upd_taken && (upd_target != upd_pred_target)));
      redirect_valid = rst_n && redirect_raw;
      redirect_pc    = '0;
      if (redirect_valid) begin
         redirect_pc = upd_taken ? upd_target : (upd_pc + DATA_WIDTH'(4));
      end
   end

   // Performance counters, free-running and wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         if (upd_valid) begin
            branch_cnt_q <= branch_cnt_q + 32'd1;
         end
         if (redirect_valid) begin
            mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
         end
      end
   end

   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;

endmodule
